// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state encoding and round primitives
// for the streaming core and its combinational round step.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_ADD   = 3'd3,
    ST_PAD2  = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Second block of SHA-256d after the 256-bit first digest: pad bit, zeros, length 256.
  localparam logic [255:0] PAD2_TAIL = {32'h80000000, 192'h0, 32'h00000100};

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sha256_k(input logic [5:0] idx);
    return K_TABLE[idx];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_stream_core_round_step.sv
// One combinational SHA-256 round: compresses one word and slides the
// 16-word schedule window (oldest word in the top 32 bits).
module sha256_round_step
  import sha256_pkg::*;
(
  input  logic [255:0] i_vars,
  input  logic [511:0] i_sched,
  input  logic [5:0]   i_round,
  output logic [255:0] o_vars,
  output logic [511:0] o_sched
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w0, w1, w9, w14;
  logic [31:0] t1, t2, w_new;

  assign {a, b, c, d, e, f, g, h} = i_vars;

  // Window word j lives at bits [511-32j -: 32].
  assign w0  = i_sched[511:480];
  assign w1  = i_sched[479:448];
  assign w9  = i_sched[223:192];
  assign w14 = i_sched[63:32];

  assign t1    = h + big_sigma1(e) + ch(e, f, g) + sha256_k(i_round) + w0;
  assign t2    = big_sigma0(a) + maj(a, b, c);
  assign w_new = small_sigma1(w14) + w9 + small_sigma0(w1) + w0;

  assign o_vars  = {t1 + t2, a, b, c, d + t1, e, f, g};
  assign o_sched = {i_sched[479:0], w_new};

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 / SHA-256d engine: 16 words in over valid/ready,
// ROUNDS_PER_CYCLE rounds per clock, digest out over a held valid/ready.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_DOUBLE   = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [31:0]  i_data,
  input  logic         i_first,
  input  logic         i_last,
  input  logic         i_double,
  output logic         o_digest_valid,
  input  logic         i_digest_ready,
  output logic [255:0] o_digest,
  output logic         o_busy
);

  localparam int RPC = ROUNDS_PER_CYCLE;
  localparam logic [5:0] LAST_GROUP = 6'(64 - RPC);
  localparam logic [5:0] RPC_STEP   = 6'(RPC);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
    $fatal(1, "sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Input handshake: a word moves when i_valid && o_ready at a rising edge;
  // output handshake: o_digest is held with o_digest_valid until i_digest_ready.
  state_t        state_q, state_d;
  logic [3:0]    word_cnt_q;
  logic [5:0]    round_q;
  logic [511:0]  sched_q;
  logic [255:0]  vars_q;
  logic [255:0]  h_q;
  logic [255:0]  h_sum;
  logic          last_q, double_q, second_q;
  logic [255:0]  digest_q;
  logic          digest_valid_q;
  logic          transfer;
  logic [255:0]  vars_next;
  logic [511:0]  sched_next;

  assign transfer = i_valid && o_ready;

  for (genvar gi = 0; gi < RPC; gi++) begin : g_round
    logic [255:0] v_in, v_out;
    logic [511:0] s_in, s_out;
    logic [5:0]   idx;
    if (gi == 0) begin : g_head
      assign v_in = vars_q;
      assign s_in = sched_q;
    end else begin : g_tail
      assign v_in = g_round[gi-1].v_out;
      assign s_in = g_round[gi-1].s_out;
    end
    assign idx = round_q + 6'(gi);
    sha256_round_step u_step (
      .i_vars  (v_in),
      .i_sched (s_in),
      .i_round (idx),
      .o_vars  (v_out),
      .o_sched (s_out)
    );
  end

  assign vars_next  = g_round[RPC-1].v_out;
  assign sched_next = g_round[RPC-1].s_out;

  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[32*i +: 32] = h_q[32*i +: 32] + vars_q[32*i +: 32];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (transfer) state_d = ST_LOAD;
      ST_LOAD:  if (transfer && word_cnt_q == 4'd15) state_d = ST_ROUND;
      ST_ROUND: if (round_q == LAST_GROUP) state_d = ST_ADD;
      ST_ADD: begin
        if (!last_q)                   state_d = ST_IDLE;
        else if (double_q && !second_q) state_d = ST_PAD2;
        else                            state_d = ST_OUT;
      end
      ST_PAD2:  state_d = ST_ROUND;
      ST_OUT:   if (digest_valid_q && i_digest_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    o_busy  = (state_q != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      word_cnt_q     <= '0;
      round_q        <= '0;
      sched_q        <= '0;
      vars_q         <= '0;
      h_q            <= SHA256_IV;
      last_q         <= 1'b0;
      double_q       <= 1'b0;
      second_q       <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (transfer) begin
            sched_q    <= {sched_q[479:0], i_data};
            word_cnt_q <= 4'd1;
            last_q     <= i_last;
            second_q   <= 1'b0;
            round_q    <= '0;
            if (i_first) begin
              double_q <= SUPPORT_DOUBLE && i_double;
              h_q      <= SHA256_IV;
              vars_q   <= SHA256_IV;
            end else begin
              vars_q   <= h_q;
            end
          end
        end
        ST_LOAD: begin
          if (transfer) begin
            sched_q    <= {sched_q[479:0], i_data};
            word_cnt_q <= word_cnt_q + 4'd1;
          end
        end
        ST_ROUND: begin
          vars_q  <= vars_next;
          sched_q <= sched_next;
          round_q <= round_q + RPC_STEP;
        end
        ST_ADD: h_q <= h_sum;
        ST_PAD2: begin
          sched_q  <= {h_q, PAD2_TAIL};
          h_q      <= SHA256_IV;
          vars_q   <= SHA256_IV;
          second_q <= 1'b1;
          round_q  <= '0;
        end
        ST_OUT: begin
          // First OUT cycle registers the digest; it then holds until accepted.
          if (!digest_valid_q) begin
            digest_valid_q <= 1'b1;
            digest_q       <= h_q;
          end else if (i_digest_ready) begin
            digest_valid_q <= 1'b0;
            last_q         <= 1'b0;
            double_q       <= 1'b0;
            second_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_digest_valid = digest_valid_q;
  assign o_digest       = digest_q;

endmodule
